// File: rtl/codificador_prioridade_if.sv
// Request/encoded-result bundle for the registered priority encoder.
// master drives the request side; slave is the encoder itself.
interface codificador_prioridade_if #(
    parameter int IN_WIDTH = 16
);
    localparam int OUT_WIDTH = $clog2(IN_WIDTH);

    logic                 en;
    logic [IN_WIDTH-1:0]  in;
    logic [OUT_WIDTH-1:0] out;
    logic                 valid;
    logic                 multi;

    modport master (
        output en,
        output in,
        input  out,
        input  valid,
        input  multi
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output valid,
        output multi
    );
endinterface

// File: rtl/codificador_prioridade.sv
// Registered IN_WIDTH-to-log2 priority encoder: highest set request bit wins,
// with valid (any request) and multi (two or more requests) flags, one cycle latency.
module codificador_prioridade #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
    input logic                     clk,
    input logic                     rst_n,
    codificador_prioridade_if.slave bus
);

    logic [OUT_WIDTH-1:0] enc_idx;
    logic                 enc_valid;
    logic                 enc_multi;

    logic [OUT_WIDTH-1:0] out_d,   out_q;
    logic                 valid_d, valid_q;
    logic                 multi_d, multi_q;

    // Ascending scan so the last (highest) set bit overwrites earlier hits.
    always_comb begin
        // NOTE: default first so every path assigns enc_idx and no latch is inferred.
        enc_idx = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (bus.in[i]) begin
                enc_idx = OUT_WIDTH'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign enc_valid = |bus.in;
    assign enc_multi = |(bus.in & (bus.in - IN_WIDTH'(1)));

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        multi_d = multi_q;
        if (bus.en) begin
            out_d   = enc_idx;
            valid_d = enc_valid;
            multi_d = enc_multi;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.multi = multi_q;

endmodule

// File: tb/tb_codificador_prioridade.sv
// Directed self-checking bench for codificador_prioridade: reset, walking one,
// zero input, contention, enable hold, latency and asynchronous reset.
module tb_codificador_prioridade;

    localparam int IN_WIDTH  = 16;
    localparam int OUT_WIDTH = 4;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    codificador_prioridade_if #(.IN_WIDTH(IN_WIDTH)) bus ();

    codificador_prioridade #(.IN_WIDTH(IN_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // Advance past the next rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.en = 1'b1;
        bus.in = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.out !== 4'd0 || bus.valid !== 1'b0 || bus.multi !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got out=%0d valid=%b multi=%b, want out=0 valid=0 multi=0",
                         c, bus.out, bus.valid, bus.multi);
            end
        end
        #2 rst_n = 1'b1;
        // First edge after release loads immediately.
        step();
        checks++;
        if (bus.out !== 4'd15 || bus.valid !== 1'b1 || bus.multi !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got out=%0d valid=%b multi=%b, want out=15 valid=1 multi=1",
                     bus.out, bus.valid, bus.multi);
        end
    endtask

    task automatic test_walking_one();
        logic [IN_WIDTH-1:0] one;
        one    = 16'h0001;
        bus.en = 1'b1;
        for (int k = IN_WIDTH - 1; k >= 0; k--) begin
            bus.in = one << k;
            step();
            checks++;
            if (bus.out !== OUT_WIDTH'(k) || bus.valid !== 1'b1 || bus.multi !== 1'b0) begin
                errors++;
                $display("FAIL walking_one bit %0d: got out=%0d valid=%b multi=%b, want out=%0d valid=1 multi=0",
                         k, bus.out, bus.valid, bus.multi, k);
            end
        end
    endtask

    task automatic test_zero();
        bus.en = 1'b1;
        bus.in = 16'h0000;
        step();
        checks++;
        if (bus.out !== 4'd0 || bus.valid !== 1'b0 || bus.multi !== 1'b0) begin
            errors++;
            $display("FAIL zero_input: got out=%0d valid=%b multi=%b, want out=0 valid=0 multi=0",
                     bus.out, bus.valid, bus.multi);
        end
        bus.in = 16'h0001;
        step();
        checks++;
        if (bus.out !== 4'd0 || bus.valid !== 1'b1 || bus.multi !== 1'b0) begin
            errors++;
            $display("FAIL request_zero: got out=%0d valid=%b multi=%b, want out=0 valid=1 multi=0",
                     bus.out, bus.valid, bus.multi);
        end
    endtask

    task automatic test_priority();
        logic [IN_WIDTH-1:0]  vec   [5];
        logic [OUT_WIDTH-1:0] exp_o [5];
        logic                 exp_m [5];
        vec[0] = 16'b0100_0000_0000_0101; exp_o[0] = 4'd14; exp_m[0] = 1'b1;
        vec[1] = 16'hFFFF;                exp_o[1] = 4'd15; exp_m[1] = 1'b1;
        vec[2] = 16'h0003;                exp_o[2] = 4'd1;  exp_m[2] = 1'b1;
        vec[3] = 16'h8001;                exp_o[3] = 4'd15; exp_m[3] = 1'b1;
        vec[4] = 16'h0A00;                exp_o[4] = 4'd11; exp_m[4] = 1'b1;
        bus.en = 1'b1;
        for (int t = 0; t < 5; t++) begin
            bus.in = vec[t];
            step();
            checks++;
            if (bus.out !== exp_o[t] || bus.valid !== 1'b1 || bus.multi !== exp_m[t]) begin
                errors++;
                $display("FAIL priority in=%h: got out=%0d valid=%b multi=%b, want out=%0d valid=1 multi=%b",
                         vec[t], bus.out, bus.valid, bus.multi, exp_o[t], exp_m[t]);
            end
        end
    endtask

    task automatic test_enable_hold();
        bus.en = 1'b1;
        bus.in = 16'h0100;
        step();
        checks++;
        if (bus.out !== 4'd8 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: got out=%0d valid=%b, want out=8 valid=1", bus.out, bus.valid);
        end
        bus.en = 1'b0;
        bus.in = 16'h0002;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (bus.out !== 4'd8 || bus.valid !== 1'b1 || bus.multi !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got out=%0d valid=%b multi=%b, want out=8 valid=1 multi=0",
                         c, bus.out, bus.valid, bus.multi);
            end
        end
        bus.en = 1'b1;
        step();
        checks++;
        if (bus.out !== 4'd1 || bus.valid !== 1'b1 || bus.multi !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got out=%0d valid=%b multi=%b, want out=1 valid=1 multi=0",
                     bus.out, bus.valid, bus.multi);
        end
    endtask

    task automatic test_latency();
        bus.en = 1'b1;
        bus.in = 16'h0010;
        step();
        // Change input right after the edge; outputs must keep old value all cycle.
        bus.in = 16'h0C00;
        #1;
        checks++;
        if (bus.out !== 4'd4 || bus.multi !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out=%0d multi=%b, want out=4 multi=0", bus.out, bus.multi);
        end
        #6;
        checks++;
        if (bus.out !== 4'd4 || bus.multi !== 1'b0) begin
            errors++;
            $display("FAIL latency_late: got out=%0d multi=%b, want out=4 multi=0", bus.out, bus.multi);
        end
        step();
        checks++;
        if (bus.out !== 4'd11 || bus.valid !== 1'b1 || bus.multi !== 1'b1) begin
            errors++;
            $display("FAIL latency_new: got out=%0d valid=%b multi=%b, want out=11 valid=1 multi=1",
                     bus.out, bus.valid, bus.multi);
        end
    endtask

    task automatic test_async_reset();
        bus.en = 1'b1;
        bus.in = 16'h2001;
        step();
        checks++;
        if (bus.out !== 4'd13 || bus.valid !== 1'b1 || bus.multi !== 1'b1) begin
            errors++;
            $display("FAIL async_preload: got out=%0d valid=%b multi=%b, want out=13 valid=1 multi=1",
                     bus.out, bus.valid, bus.multi);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out !== 4'd0 || bus.valid !== 1'b0 || bus.multi !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got out=%0d valid=%b multi=%b, want out=0 valid=0 multi=0",
                     bus.out, bus.valid, bus.multi);
        end
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (bus.out !== 4'd13 || bus.valid !== 1'b1 || bus.multi !== 1'b1) begin
            errors++;
            $display("FAIL async_release: got out=%0d valid=%b multi=%b, want out=13 valid=1 multi=1",
                     bus.out, bus.valid, bus.multi);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        bus.en = 1'b0;
        bus.in = '0;
        test_reset();
        test_walking_one();
        test_zero();
        test_priority();
        test_enable_hold();
        test_latency();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/codificador_prioridade.md
Name: codificador_prioridade

Overview:
- Registered 16-to-4 priority encoder.
- Reports the index of the highest-numbered asserted input bit, plus a valid flag and a "multiple requests" flag.
- Used as a request/interrupt arbiter front end: a 16-bit request vector goes in, an encoded winner index comes out one clock later.

Parameters:
- IN_WIDTH, 16, number of request inputs; must be a power of two, at least 2.
- OUT_WIDTH, $clog2(IN_WIDTH) = 4, width of the encoded index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; when low, all registered outputs hold.
- in  input  IN_WIDTH  request vector; bit i = request i.
- out  output  OUT_WIDTH  index of the highest set bit of in, registered.
- valid  output  1  registered; 1 when at least one bit of in was set.
- multi  output  1  registered; 1 when two or more bits of in were set.

Behaviour:
- Reset: while rst_n = 0, out = 0, valid = 0 and multi = 0, asynchronously and independent of clk. Reset may be asserted at any time and overrides en.
- Priority: highest index wins. If in[k] = 1 and in[j] = 0 for all j > k, the encoded result is k. Lower bits are don't-care once a higher bit is set.
- Zero input: when in = 0, the encoded result is out = 0 and valid = 0. valid distinguishes "no request" from "request 0".
- multi = 1 when popcount(in) >= 2; otherwise multi = 0.
- Timing:
  - The encode logic is purely combinational from in.
  - out, valid and multi are registered on the rising clk edge when en = 1.
  - Latency is exactly one cycle: in sampled at edge N appears on the outputs after edge N.
  - Outputs are stable between edges.
- Hold: when en = 0 at a rising edge, out, valid and multi keep their previous values.
- Reset release: the first rising edge with rst_n = 1 and en = 1 loads normally. There is no extra warm-up cycle.
- Inputs: X/Z on in is not supported. Every bit is treated as a resolved 0 or 1.
- Width rules: out is OUT_WIDTH bits with no overflow possible, since the maximum index is IN_WIDTH-1 = 15 = 4'b1111.

Test Plan:
- Reset behaviour: hold rst_n = 0 with in = 16'hFFFF and clocks running -> out = 0, valid = 0, multi = 0. Then assert rst_n = 0 mid-cycle after outputs are loaded -> outputs clear immediately, without waiting for a clock edge.
- Walking one: with en = 1, apply in = 16'h8000, 16'h4000, …, 16'h0001, one per cycle -> one cycle later out = 15, 14, …, 0 respectively, valid = 1, multi = 0 for each.
- Zero input: in = 16'h0000 -> out = 0, valid = 0, multi = 0. Compare with in = 16'h0001 -> out = 0, valid = 1.
- Priority under contention:
  - in = 16'b0100_0000_0000_0101 -> out = 14, valid = 1, multi = 1.
  - in = 16'hFFFF -> out = 15, multi = 1.
  - in = 16'h0003 -> out = 1, multi = 1.
- Enable hold: load in = 16'h0100 (out = 8), then set en = 0 and change in to 16'h0002 for 3 cycles -> out stays 8, valid stays 1. Re-assert en = 1 -> out = 1 one cycle later.
- Latency check: change in exactly at a rising edge boundary -> the new out is visible only after the following edge, never in the same cycle.
